fpga_reset_conditioner: RTL and testbench



---
 rtl/fpga_reset_conditioner_if.sv | 47 ++++
 rtl/fpga_reset_conditioner.sv | 179 +++++++++++++++++
 tb/tb_fpga_reset_conditioner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fpga_reset_conditioner_if.sv
// -----------------------------------------------------------------------------
// fpga_reset_conditioner_if
// Purpose : bundles the board-side reset/strap signals of the reset conditioner.
//           The clock and power-on reset stay as plain ports on the module.
// Signals :
//   clk_locked_i  clock-wizard locked (asynchronous to the system clock)
//   btn_rst_i     raw reset pushbutton, active-high, bouncing
//   sw_i          raw strap switches (bit 0 boot_select, bit 1 execute_from_flash)
//   rst_no        conditioned system reset, active-low, registered
//   sw_o          debounced strap values, frozen while the system runs
//   rst_led_o     copy of rst_no for a board LED
//   state_o       debug view of the conditioner state (0 = HOLD, 1 = RUN)
//   rst_cause_o   cause of the last HOLD entry (only with RST_COND_CAUSE_EN)
// Modports: master = board/testbench side, slave = conditioner side.
// -----------------------------------------------------------------------------
interface fpga_reset_conditioner_if #(
   parameter int NUM_SW = 2
);
   logic              clk_locked_i;
   logic              btn_rst_i;
   logic [NUM_SW-1:0] sw_i;
   logic              rst_no;
   logic [NUM_SW-1:0] sw_o;
   logic              rst_led_o;
   logic              state_o;
`ifdef RST_COND_CAUSE_EN
   logic [1:0]        rst_cause_o;
`endif

   // Level signals only: no valid/ready handshake. Inputs may change at any
   // time; outputs change only on the system clock or the power-on reset.
   modport master (
      output clk_locked_i, btn_rst_i, sw_i,
      input  rst_no, sw_o, rst_led_o, state_o
`ifdef RST_COND_CAUSE_EN
      , input rst_cause_o
`endif
   );

   modport slave (
      input  clk_locked_i, btn_rst_i, sw_i,
      output rst_no, sw_o, rst_led_o, state_o
`ifdef RST_COND_CAUSE_EN
      , output rst_cause_o
`endif
   );
endinterface

// File: rtl/fpga_reset_conditioner.sv
// -----------------------------------------------------------------------------
// fpga_reset_conditioner
// Purpose : merges power-on reset, clock-wizard lock and a bouncing pushbutton
//           into one clean active-low system reset, and debounces/freezes the
//           strap switches so they are stable across every reset release.
// Ports   :
//   clk_i   system clock (clock-wizard output)
//   rst_i   power-on reset, asynchronous, active-high; clears every flop
//   bus     fpga_reset_conditioner_if.slave (lock, button, straps in;
//           rst_no, sw_o, rst_led_o, state_o out)
// Option  : define RST_COND_CAUSE_EN to add bus.rst_cause_o
//           (0 power-on, 1 button, 2 lock loss, 3 both on the same cycle).
// -----------------------------------------------------------------------------
module fpga_reset_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int NUM_SW          = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   fpga_reset_conditioner_if.slave  bus
);

   localparam int NIN   = NUM_SW + 2;  // lock, button, straps
   localparam int NDB   = NUM_SW + 1;  // button, straps
   localparam int DB_CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HC_W  = $clog2(RST_HOLD_CYCLES + 1);

   // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing edge,
   // i.e. when the counter already holds DEBOUNCE_CYCLES-1.
   localparam logic [DB_CW-1:0] DB_LAST   = DB_CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(RST_HOLD_CYCLES);
   localparam logic [HC_W-1:0]  HOLD_ONE  = HC_W'(1);

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // ---------------------------------------------------------------- sync
   logic [NIN-1:0]    w_raw;
   logic [NIN-1:0]    r_sync [SYNC_STAGES];
   logic [NIN-1:0]    w_sync;
   logic              w_lock_q;
   logic [NDB-1:0]    w_db_in;

   assign w_raw    = {bus.sw_i, bus.btn_rst_i, bus.clk_locked_i};
   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_lock_q = w_sync[0];
   assign w_db_in  = w_sync[NIN-1:1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= w_raw;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // ------------------------------------------------------------ debounce
   // Index 0 is the button, indices 1.. are the straps.
   logic [NDB-1:0]    w_db;
   logic              w_btn_db;
   logic [NUM_SW-1:0] w_sw_db;

   assign w_btn_db = w_db[0];
   assign w_sw_db  = w_db[NDB-1:1];

   for (genvar g = 0; g < NDB; g++) begin : g_db
      logic             r_bit;
      logic [DB_CW-1:0] r_cnt;

      // Any cycle of agreement restarts the count, so bounces never flip.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_bit <= 1'b0;
            r_cnt <= '0;
         end else if (w_db_in[g] == r_bit) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_LAST) begin
            r_bit <= ~r_bit;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_db[g] = r_bit;
   end

   // ----------------------------------------------------------------- FSM
   state_t           r_state;
   state_t           w_state_next;
   logic [HC_W-1:0]  r_hold_cnt;
   logic             w_qualified;
   logic             w_rst_n_next;
   logic             w_sw_load;
   logic             w_hold_entry;

   // Conditions under which the system may run.
   assign w_qualified = w_lock_q & ~w_btn_db;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_HOLD;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_HOLD: if (w_qualified && (r_hold_cnt == HOLD_ONE)) w_state_next = ST_RUN;
         ST_RUN:  if (!w_qualified)                            w_state_next = ST_HOLD;
         default:                                              w_state_next = ST_HOLD;
      endcase
   end

   // Output decode (registered below)
   always_comb begin
      w_rst_n_next = 1'b0;
      w_sw_load    = 1'b0;
      w_hold_entry = 1'b0;
      w_rst_n_next = (w_state_next == ST_RUN);
      w_sw_load    = (r_state == ST_HOLD);
      w_hold_entry = (r_state == ST_RUN) && (w_state_next == ST_HOLD);
   end

   // Hold counter: any disqualifying cycle reloads it, including the
   // RUN->HOLD edge, so the full hold always follows the last disturbance.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hold_cnt <= HOLD_INIT;
      end else if (!w_qualified) begin
         r_hold_cnt <= HOLD_INIT;
      end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
         r_hold_cnt <= r_hold_cnt - 1'b1;
      end
   end

   // -------------------------------------------------------------- outputs
   logic              r_rst_n;
   logic [NUM_SW-1:0] r_sw_o;

   // rst_no is taken from the next state so it rises on the same edge the
   // FSM enters RUN, and falls on the edge it re-enters HOLD.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rst_n <= 1'b0;
         r_sw_o  <= '0;
      end else begin
         r_rst_n <= w_rst_n_next;
         if (w_sw_load) r_sw_o <= w_sw_db;
      end
   end

   assign bus.rst_no    = r_rst_n;
   assign bus.rst_led_o = r_rst_n;
   assign bus.sw_o      = r_sw_o;
   assign bus.state_o   = r_state;

`ifdef RST_COND_CAUSE_EN
   logic [1:0] r_cause;

   // Bit 1 = lock loss, bit 0 = button; both set when they coincide.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)             r_cause <= 2'd0;
      else if (w_hold_entry) r_cause <= {~w_lock_q, w_btn_db};
   end

   assign bus.rst_cause_o = r_cause;
`else
   logic w_unused_hold_entry;
   assign w_unused_hold_entry = w_hold_entry;
`endif

endmodule

// File: tb/tb_fpga_reset_conditioner.sv
module tb_fpga_reset_conditioner;

  localparam int NUM_SW = 2;

  localparam int SEL_RST   = 0;
  localparam int SEL_LED   = 1;
  localparam int SEL_SW    = 2;
  localparam int SEL_STATE = 3;
  localparam int SEL_CAUSE = 4;

  // ---------------------------------------------------------- clock/reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  fpga_reset_conditioner_if #(.NUM_SW(NUM_SW)) bus ();

  fpga_reset_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .RST_HOLD_CYCLES (16),
    .NUM_SW          (NUM_SW)
  ) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // ----------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] observe(input int sel);
    logic [7:0] v;
    v = 8'hff;
    case (sel)
      SEL_RST:   v = {7'd0, bus.rst_no};
      SEL_LED:   v = {7'd0, bus.rst_led_o};
      SEL_SW:    v = {6'd0, bus.sw_o};
      SEL_STATE: v = {7'd0, bus.state_o};
`ifdef RST_COND_CAUSE_EN
      SEL_CAUSE: v = {6'd0, bus.rst_cause_o};
`endif
      default:   v = 8'hff;
    endcase
    return v;
  endfunction

  task automatic compare(input string tag, input int sel);
    logic [7:0] exp;
    logic [7:0] obs;
    exp = exp_q.pop_front();
    obs = observe(sel);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- driver tasks
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic expect_after(input int n, input string tag, input int sel,
                              input logic [7:0] exp);
    exp_q.push_back(exp);
    if (n > 0) wait_edges(n);
    compare(tag, sel);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    bus.clk_locked_i = 1'b1;
    bus.btn_rst_i    = 1'b0;
    bus.sw_i         = 2'b01;

    // Reset values while rst_i is high
    @(negedge clk_i);
    expect_after(0, "reset_rst_no", SEL_RST,   8'd0);
    expect_after(0, "reset_led",    SEL_LED,   8'd0);
    expect_after(0, "reset_sw_o",   SEL_SW,    8'd0);
    expect_after(0, "reset_state",  SEL_STATE, 8'd0);
`ifdef RST_COND_CAUSE_EN
    expect_after(0, "reset_cause",  SEL_CAUSE, 8'd0);
`endif

    // Power-on release: low through edge 17, high after edge 18
    rst_i = 1'b0;
    expect_after(17, "por_edge17_rst_no", SEL_RST,   8'd0);
    expect_after(0,  "por_edge17_led",    SEL_LED,   8'd0);
    expect_after(1,  "por_edge18_rst_no", SEL_RST,   8'd1);
    expect_after(0,  "por_edge18_led",    SEL_LED,   8'd1);
    expect_after(0,  "por_edge18_state",  SEL_STATE, 8'd1);
    expect_after(0,  "por_sw_o",          SEL_SW,    8'd1);

    // Straps change in RUN: sw_o stays frozen
    bus.sw_i = 2'b10;
    expect_after(50, "freeze_sw_o",   SEL_SW,  8'd1);
    expect_after(0,  "freeze_rst_no", SEL_RST, 8'd1);

    // Clean button press: btn_db at edge 10, rst_no low after edge 11
    bus.btn_rst_i = 1'b1;
    expect_after(10, "btn_edge10_rst_no", SEL_RST,   8'd1);
    expect_after(1,  "btn_edge11_rst_no", SEL_RST,   8'd0);
    expect_after(0,  "btn_edge11_led",    SEL_LED,   8'd0);
    expect_after(0,  "btn_edge11_state",  SEL_STATE, 8'd0);
    expect_after(1,  "btn_hold_sw_o",     SEL_SW,    8'd2);
`ifdef RST_COND_CAUSE_EN
    expect_after(0,  "btn_cause",         SEL_CAUSE, 8'd1);
`endif

    // Button release: rst_no rises exactly 2+8+16 edges later
    bus.btn_rst_i = 1'b0;
    expect_after(25, "rel_edge25_rst_no", SEL_RST, 8'd0);
    expect_after(1,  "rel_edge26_rst_no", SEL_RST, 8'd1);

    // Bouncing button, toggling every 5 cycles for 100 cycles
    for (int i = 0; i < 20; i++) begin
      bus.btn_rst_i = ~bus.btn_rst_i;
      expect_after(5, "bounce_rst_no", SEL_RST, 8'd1);
    end
    bus.btn_rst_i = 1'b0;
    expect_after(10, "bounce_after_rst_no", SEL_RST,   8'd1);
    expect_after(0,  "bounce_after_state",  SEL_STATE, 8'd1);

    // One-cycle lock loss in RUN
    bus.clk_locked_i = 1'b0;
    wait_edges(1);
    bus.clk_locked_i = 1'b1;
    expect_after(1,  "lock_edge2_rst_no",  SEL_RST, 8'd1);
    expect_after(1,  "lock_edge3_rst_no",  SEL_RST, 8'd0);
`ifdef RST_COND_CAUSE_EN
    expect_after(0,  "lock_cause",         SEL_CAUSE, 8'd2);
`endif
    expect_after(15, "lock_edge18_rst_no", SEL_RST, 8'd0);
    expect_after(1,  "lock_edge19_rst_no", SEL_RST, 8'd1);

    // Lock loss again, then power-on reset when the hold count is 5
    bus.clk_locked_i = 1'b0;
    wait_edges(1);
    bus.clk_locked_i = 1'b1;
    expect_after(13, "midhold_state", SEL_STATE, 8'd0);
    #2 rst_i = 1'b1;
    #1;
    expect_after(0, "async_rst_no", SEL_RST,   8'd0);
    expect_after(0, "async_led",    SEL_LED,   8'd0);
    expect_after(0, "async_sw_o",   SEL_SW,    8'd0);
    expect_after(0, "async_state",  SEL_STATE, 8'd0);
`ifdef RST_COND_CAUSE_EN
    expect_after(0, "async_cause",  SEL_CAUSE, 8'd0);
`endif

    // Second power-on release starts from scratch
    @(negedge clk_i);
    rst_i = 1'b0;
    expect_after(17, "por2_edge17_rst_no", SEL_RST, 8'd0);
    expect_after(1,  "por2_edge18_rst_no", SEL_RST, 8'd1);
    expect_after(0,  "por2_sw_o",          SEL_SW,  8'd2);

    // Lock loss after the second release
    bus.clk_locked_i = 1'b0;
    wait_edges(1);
    bus.clk_locked_i = 1'b1;
    expect_after(2, "lock2_rst_no", SEL_RST, 8'd0);
`ifdef RST_COND_CAUSE_EN
    expect_after(0, "lock2_cause",  SEL_CAUSE, 8'd2);
`endif
    expect_after(16, "lock2_release_rst_no", SEL_RST, 8'd1);

    // ---------------------------------------------------------- report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
